switch_cfg_loader: RTL and testbench

- Serial configuration controller for the 5x5 routing switch box; one per switch box.
- Receives a framed serial bitstream, validates it, and commits it atomically to the active route-select registers that drive the box's top/bottom/left/right mux selects.
- Sits between the fabric configuration chain and the switch box. It replaces the box's power-on-zero constant configuration.

---
 rtl/switch_cfg_loader.sv | 208 ++++++++++++++++++++
 tb/tb_switch_cfg_loader.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_cfg_loader.sv
// -----------------------------------------------------------------------------
// switch_cfg_loader
//
// Serial configuration controller for one 5x5 routing switch box. It hunts
// for the sync byte in a serial bitstream, captures 18 six-bit route entries
// plus a checksum into a shadow register, validates the frame, and commits it
// atomically to the active route-select registers.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   cfg_din    serial configuration bit (MSB-first per field)
//   cfg_valid  cfg_din is valid this cycle
//   cfg_ready  loader accepts a bit this cycle (low only in COMMIT)
//   cfg_abort  drop the frame in progress, return to IDLE
//   cfg_clear  zero all active entries
//   cfg_top    active top entries, entry i in bits [6i+5:6i]
//   cfg_bottom active bottom entries
//   cfg_left   active left entries
//   cfg_right  active right entries
//   cfg_busy   loader is not in IDLE
//   cfg_done   one-cycle pulse on a successful commit
//   cfg_err    one-cycle pulse on a rejected frame
//   err_code   01 checksum error, 10 illegal entry, 00 after a good frame
// -----------------------------------------------------------------------------
module switch_cfg_loader #(
    parameter int          N_TB = 5,
    parameter int          N_LR = 4,
    parameter logic [7:0]  SYNC = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_din,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  cfg_abort,
    input  logic                  cfg_clear,
    output logic [6*N_TB-1:0]     cfg_top,
    output logic [6*N_TB-1:0]     cfg_bottom,
    output logic [6*N_LR-1:0]     cfg_left,
    output logic [6*N_LR-1:0]     cfg_right,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic [1:0]            err_code
);

    localparam int N_ENT    = 2*N_TB + 2*N_LR;
    localparam int ENT_BITS = 6*N_ENT;
    localparam int CNT_W    = $clog2(ENT_BITS);

    typedef enum logic [1:0] {IDLE, LOAD, CHK, COMMIT} state_t;

    state_t               state;
    logic [7:0]           win;
    logic [CNT_W-1:0]     bitcnt;
    logic [2:0]           epos;
    logic [7:0]           sum;
    logic                 illegal;
    logic [ENT_BITS-1:0]  shadow;
    logic [7:0]           chk;
    // Active entries kept in frame order: entry 0 (top0) occupies the MSBs.
    logic [ENT_BITS-1:0]  act;

    logic                 xfer;
    logic [7:0]           win_next;
    logic [5:0]           ent_next;

    // Side codes: 0 off, 1 top, 2 right, 3 bottom, 4 left. An "off" entry is
    // legal whatever its index field holds.
    function automatic logic entry_illegal(input logic [5:0] e);
        logic [2:0] side;
        logic [2:0] idx;
        side = e[2:0];
        idx  = e[5:3];
        if (side > 3'd4)
            return 1'b1;
        if ((side == 3'd1 || side == 3'd3) && int'(idx) >= N_TB)
            return 1'b1;
        if ((side == 3'd2 || side == 3'd4) && int'(idx) >= N_LR)
            return 1'b1;
        return 1'b0;
    endfunction

    assign cfg_ready = (state != COMMIT);
    assign cfg_busy  = (state != IDLE);
    assign xfer      = cfg_valid && cfg_ready;
    // Lookahead values include the bit transferring this cycle.
    assign win_next  = {win[6:0], cfg_din};
    assign ent_next  = {shadow[4:0], cfg_din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            win      <= '0;
            bitcnt   <= '0;
            epos     <= '0;
            sum      <= '0;
            illegal  <= 1'b0;
            shadow   <= '0;
            chk      <= '0;
            act      <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            err_code <= 2'b00;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;

            // A successful commit below overrides this, so commit wins a tie.
            if (cfg_clear)
                act <= '0;

            if (cfg_abort) begin
                state   <= IDLE;
                win     <= '0;
                bitcnt  <= '0;
                epos    <= '0;
                sum     <= '0;
                illegal <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (xfer) begin
                            if (win_next == SYNC) begin
                                state   <= LOAD;
                                win     <= '0;
                                bitcnt  <= '0;
                                epos    <= '0;
                                sum     <= '0;
                                illegal <= 1'b0;
                            end else begin
                                win <= win_next;
                            end
                        end
                    end

                    LOAD: begin
                        if (xfer) begin
                            shadow <= {shadow[ENT_BITS-2:0], cfg_din};
                            if (epos == 3'd5) begin
                                epos <= '0;
                                sum  <= sum + {2'b00, ent_next};
                                if (entry_illegal(ent_next))
                                    illegal <= 1'b1;
                            end else begin
                                epos <= epos + 3'd1;
                            end
                            if (bitcnt == CNT_W'(ENT_BITS-1)) begin
                                bitcnt <= '0;
                                state  <= CHK;
                            end else begin
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end
                    end

                    CHK: begin
                        if (xfer) begin
                            chk <= {chk[6:0], cfg_din};
                            if (bitcnt == CNT_W'(7)) begin
                                bitcnt <= '0;
                                state  <= COMMIT;
                            end else begin
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end
                    end

                    COMMIT: begin
                        state <= IDLE;
                        win   <= '0;
                        if (illegal) begin
                            cfg_err  <= 1'b1;
                            err_code <= 2'b10;
                        end else if (chk != sum) begin
                            cfg_err  <= 1'b1;
                            err_code <= 2'b01;
                        end else begin
                            act      <= shadow;
                            cfg_done <= 1'b1;
                            err_code <= 2'b00;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Unpack frame-ordered entries onto the per-side buses.
    always_comb begin
        cfg_top    = '0;
        cfg_bottom = '0;
        cfg_left   = '0;
        cfg_right  = '0;
        for (int i = 0; i < N_TB; i++) begin
            cfg_top[6*i +: 6]    = act[ENT_BITS-1-6*i -: 6];
            cfg_bottom[6*i +: 6] = act[ENT_BITS-1-6*(N_TB+i) -: 6];
        end
        for (int i = 0; i < N_LR; i++) begin
            cfg_left[6*i +: 6]  = act[ENT_BITS-1-6*(2*N_TB+i) -: 6];
            cfg_right[6*i +: 6] = act[ENT_BITS-1-6*(2*N_TB+N_LR+i) -: 6];
        end
    end

endmodule

// File: tb/tb_switch_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_switch_cfg_loader
//
// Directed bench for switch_cfg_loader. A frame-level reference model tracks
// the received bit stream and predicts all outputs each cycle; literal checks
// pin the key values of each scenario.
// -----------------------------------------------------------------------------
module tb_switch_cfg_loader;

    localparam int N_TB = 5;
    localparam int N_LR = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cfg_din = 1'b0;
    logic                 cfg_valid = 1'b0;
    logic                 cfg_ready;
    logic                 cfg_abort = 1'b0;
    logic                 cfg_clear = 1'b0;
    logic [6*N_TB-1:0]    cfg_top;
    logic [6*N_TB-1:0]    cfg_bottom;
    logic [6*N_LR-1:0]    cfg_left;
    logic [6*N_LR-1:0]    cfg_right;
    logic                 cfg_busy;
    logic                 cfg_done;
    logic                 cfg_err;
    logic [1:0]           err_code;

    switch_cfg_loader #(.N_TB(N_TB), .N_LR(N_LR), .SYNC(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_din(cfg_din), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_abort(cfg_abort), .cfg_clear(cfg_clear),
        .cfg_top(cfg_top), .cfg_bottom(cfg_bottom), .cfg_left(cfg_left),
        .cfg_right(cfg_right), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    int  m_act[18];
    int  m_hist;
    bit  m_locked;
    bit  m_pending;
    bit  m_bits[$];
    bit  m_ready, m_busy, m_done, m_err;
    int  m_code;

    function automatic bit ent_ok(input int e);
        int side, idx;
        side = e & 7;
        idx  = e >> 3;
        if (side > 4) return 1'b0;
        if ((side == 1 || side == 3) && idx >= N_TB) return 1'b0;
        if ((side == 2 || side == 4) && idx >= N_LR) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        foreach (m_act[k]) m_act[k] = 0;
        m_hist = 0; m_locked = 0; m_pending = 0; m_bits.delete();
        m_ready = 1; m_busy = 0; m_done = 0; m_err = 0; m_code = 0;
    endtask

    task automatic model_step();
        int  e[18];
        int  s, c;
        bit  legal, ok;
        bit  accept;
        accept = cfg_valid && !m_pending;
        m_done = 0; m_err = 0; ok = 0;
        if (m_pending) begin
            m_pending = 0;
            if (!cfg_abort) begin
                s = 0; legal = 1; c = 0;
                for (int k = 0; k < 18; k++) begin
                    e[k] = 0;
                    for (int j = 0; j < 6; j++) e[k] = e[k] * 2 + int'(m_bits[6*k+j]);
                    s += e[k];
                    if (!ent_ok(e[k])) legal = 0;
                end
                for (int j = 0; j < 8; j++) c = c * 2 + int'(m_bits[108+j]);
                if (!legal)                 begin m_err = 1; m_code = 2; end
                else if (c != (s % 256))    begin m_err = 1; m_code = 1; end
                else begin
                    ok = 1; m_done = 1; m_code = 0;
                    for (int k = 0; k < 18; k++) m_act[k] = e[k];
                end
            end
            m_bits.delete();
        end
        if (cfg_clear && !ok) foreach (m_act[k]) m_act[k] = 0;
        if (cfg_abort) begin
            m_locked = 0; m_hist = 0; m_bits.delete();
        end else if (accept) begin
            if (!m_locked) begin
                m_hist = ((m_hist << 1) | int'(cfg_din)) & 255;
                if (m_hist == 8'hA5) begin m_locked = 1; m_hist = 0; end
            end else begin
                m_bits.push_back(cfg_din);
                if (m_bits.size() == 116) begin m_locked = 0; m_pending = 1; end
            end
        end
        m_ready = !m_pending;
        m_busy  = m_locked || m_pending;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [6*N_TB-1:0] et, eb;
        logic [6*N_LR-1:0] el, er;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                et = '0; eb = '0; el = '0; er = '0;
                for (int i = 0; i < N_TB; i++) begin
                    et[6*i +: 6] = 6'(m_act[i]);
                    eb[6*i +: 6] = 6'(m_act[N_TB+i]);
                end
                for (int i = 0; i < N_LR; i++) begin
                    el[6*i +: 6] = 6'(m_act[2*N_TB+i]);
                    er[6*i +: 6] = 6'(m_act[2*N_TB+N_LR+i]);
                end
                check("ready",    64'(cfg_ready),  64'(m_ready));
                check("busy",     64'(cfg_busy),   64'(m_busy));
                check("done",     64'(cfg_done),   64'(m_done));
                check("err",      64'(cfg_err),    64'(m_err));
                check("err_code", 64'(err_code),   64'(m_code));
                check("top",      64'(cfg_top),    64'(et));
                check("bottom",   64'(cfg_bottom), 64'(eb));
                check("left",     64'(cfg_left),   64'(el));
                check("right",    64'(cfg_right),  64'(er));
                if (cfg_done) done_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [5:0] ents[18];
    bit         use_gaps = 0;

    task automatic clear_ents();
        foreach (ents[k]) ents[k] = 6'd0;
    endtask

    task automatic send_bit(input logic b);
        if (use_gaps && $urandom_range(0, 1) == 1) begin
            @(negedge clk);
            cfg_valid = 1'b0;
        end
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_din   = b;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int j = 7; j >= 0; j--) send_bit(v[j]);
    endtask

    // Sends SYNC, the first n_ent_bits entry bits, and optionally the checksum.
    // fix_chk=1 sends the true sum, otherwise chk_val.
    task automatic send_frame(input bit fix_chk, input logic [7:0] chk_val,
                              input int n_ent_bits, input bit with_chk);
        logic [7:0] s;
        int n;
        s = 8'd0; n = 0;
        foreach (ents[k]) s = s + {2'b00, ents[k]};
        send_byte(8'hA5);
        for (int k = 0; k < 18; k++)
            for (int j = 5; j >= 0; j--)
                if (n < n_ent_bits) begin send_bit(ents[k][j]); n++; end
        if (with_chk) send_byte(fix_chk ? s : chk_val);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called #1 after the last bit's transfer edge: checks the COMMIT cycle,
    // then the following edge where the pulses appear.
    task automatic expect_end(input string tag, input bit exp_done, input bit exp_err,
                              input logic [1:0] exp_code);
        check({tag, "_commit_ready"}, 64'(cfg_ready), 64'd0);
        check({tag, "_commit_busy"},  64'(cfg_busy),  64'd1);
        check({tag, "_early_done"},   64'(cfg_done),  64'd0);
        @(posedge clk);
        #1;
        check({tag, "_done"},     64'(cfg_done), 64'(exp_done));
        check({tag, "_err"},      64'(cfg_err),  64'(exp_err));
        check({tag, "_code"},     64'(err_code), 64'(exp_code));
        check({tag, "_busy_low"}, 64'(cfg_busy), 64'd0);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        idle(3);
        #1;
        check("rst_top",   64'(cfg_top),  64'd0);
        check("rst_ready", 64'(cfg_ready), 64'd1);
        check("rst_busy",  64'(cfg_busy), 64'd0);
        check("rst_code",  64'(err_code), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // 1: all-zero frame
        clear_ents();
        d0 = done_cnt;
        send_frame(1'b0, 8'h00, 108, 1'b1);
        expect_end("zero", 1'b1, 1'b0, 2'b00);
        check("zero_top", 64'(cfg_top), 64'd0);
        idle(3);
        check("zero_done_once", 64'(done_cnt - d0), 64'd1);

        // 2: top0 = bottom[1], CHK 0x0B
        clear_ents();
        ents[0] = 6'b001011;
        send_frame(1'b0, 8'h0B, 108, 1'b1);
        expect_end("top0", 1'b1, 1'b0, 2'b00);
        check("top0_val",  64'(cfg_top), 64'h0B);
        check("top0_left", 64'(cfg_left), 64'd0);
        idle(3);

        // 3: bad checksum
        send_frame(1'b0, 8'h0C, 108, 1'b1);
        expect_end("badchk", 1'b0, 1'b1, 2'b01);
        check("badchk_keep", 64'(cfg_top), 64'h0B);
        idle(3);

        // 4: left2 out of range, correct CHK 0x2C
        clear_ents();
        ents[12] = 6'b101100;
        send_frame(1'b0, 8'h2C, 108, 1'b1);
        expect_end("illidx", 1'b0, 1'b1, 2'b10);
        check("illidx_keep", 64'(cfg_top), 64'h0B);
        idle(3);

        // 4b: side 5 with an also-wrong checksum: illegal wins
        clear_ents();
        ents[3] = 6'b000101;
        send_frame(1'b0, 8'h77, 108, 1'b1);
        expect_end("side5", 1'b0, 1'b1, 2'b10);
        check("side5_keep", 64'(cfg_left), 64'd0);
        idle(3);

        // 5: garbage 1011 then frame with 50% valid gaps, sum 0x48
        clear_ents();
        ents[0]  = 6'h0B;
        ents[9]  = 6'b100001;
        ents[17] = 6'b011100;
        use_gaps = 1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_frame(1'b0, 8'h48, 108, 1'b1);
        use_gaps = 0;
        expect_end("gaps", 1'b1, 1'b0, 2'b00);
        check("gaps_right3",  64'(cfg_right[23:18]),  64'h1C);
        check("gaps_bottom4", 64'(cfg_bottom[29:24]), 64'h21);
        check("gaps_top0",    64'(cfg_top[5:0]),      64'h0B);
        idle(3);

        // 6: abort after 40 entry bits, then a full frame
        send_frame(1'b1, 8'h00, 40, 1'b0);
        @(negedge clk);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        #1;
        check("abort_busy", 64'(cfg_busy), 64'd0);
        clear_ents();
        ents[1] = 6'b010010;
        send_frame(1'b0, 8'h12, 108, 1'b1);
        expect_end("postabort", 1'b1, 1'b0, 2'b00);
        check("postabort_top", 64'(cfg_top), 64'(30'h12 << 6));
        idle(3);

        // 7: reset mid-frame
        send_frame(1'b1, 8'h00, 30, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_top",   64'(cfg_top),   64'd0);
        check("midrst_busy",  64'(cfg_busy),  64'd0);
        check("midrst_ready", 64'(cfg_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // 8: commit something, then clear
        clear_ents();
        ents[14] = 6'b000010;
        send_frame(1'b0, 8'h02, 108, 1'b1);
        expect_end("preclr", 1'b1, 1'b0, 2'b00);
        check("preclr_right0", 64'(cfg_right[5:0]), 64'h02);
        @(negedge clk);
        cfg_clear = 1'b1;
        @(posedge clk);
        #1;
        cfg_clear = 1'b0;
        check("clr_right", 64'(cfg_right), 64'd0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
